demux_stream_router: RTL and testbench
======================================

Name: demux_stream_router

Overview:
Registered 1:4 stream demultiplexer that sits directly downstream of the 1:4 demux select path. It routes a single valid/ready input stream to one of four output channels, chosen per beat by a 2-bit destination field. Each channel has a one-entry output register, and stalled channels apply backpressure upstream. Per-channel saturating delivery counters provide bring-up and debug visibility.

Parameters:
WIDTH, 8, data width of each beat
CNT_W, 8, width of each per-channel delivery counter (saturating)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  router can accept the beat on in_data/in_dest
in_data  input  WIDTH  input beat payload
in_dest  input  2  destination channel 0..3
out_valid  output  4  per-channel valid; bit i = channel i
out_ready  input  4  per-channel consumer ready
out_data  output  4*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH]
cnt_clr  input  1  synchronous clear of all delivery counters
cnt  output  4*CNT_W  channel i delivery count at [i*CNT_W +: CNT_W]

Behaviour:
- Reset (async assert, sync release):
  - out_valid = 4'b0000, out_data = 0, all cnt = 0.
  - in_ready is combinational and reads 1 while in reset-released idle.
- in_ready = ~out_valid[in_dest] | out_ready[in_dest].
  - Combinational from in_dest, out_valid and out_ready.
  - No dependency on in_valid.
- Accept: in_valid & in_ready at a rising edge.
  - Channel d = in_dest loads in_data.
  - out_valid[d] <= 1.
  - Latency is 1 cycle from input handshake to out_valid.
- Deliver: out_valid[i] & out_ready[i] at a rising edge.
  - out_valid[i] <= 0, unless the same edge also accepts a beat for channel i.
- Simultaneous deliver and accept on the same channel:
  - The new beat replaces the old one and out_valid[i] stays 1.
  - Sustains 1 beat/cycle per channel when out_ready is held high.
- Stability: while out_valid[i]=1 and out_ready[i]=0, out_data[i] must not change.
- Data when idle: while out_valid[i]=0, out_data[i] holds its last loaded value. It is 0 after reset.
- Head-of-line blocking is required.
  - The input is a single ordered stream.
  - If the head beat targets a full, stalled channel, in_ready=0 and later beats for other channels wait.
- At most one channel loads per cycle. Multiple channels may deliver in the same cycle.
- Counters:
  - cnt[i] increments by 1 on each output handshake on channel i.
  - Saturates at 2^CNT_W-1; it does not wrap.
  - cnt_clr=1 sets all counters to 0 at the next edge and takes priority over a same-cycle increment.
- Reset mid-operation: buffered beats are discarded and no delivery is counted.
- in_valid=0: no state change other than deliveries and counter updates.

Test Plan:
- Reset:
  - Stimulus: assert rst with out_ready=4'b1111, in_valid=0.
  - Required: out_valid=0000, all cnt=0, in_ready=1 after release.
- Single routing:
  - Stimulus: send data 8'hA0+i to dest i=0..3 on consecutive cycles, out_ready=1111.
  - Required: each out_valid[i] pulses for exactly 1 cycle, one edge after its accept, carrying 8'hA0+i; the other out_valid bits stay 0.
  - Required counts: cnt=1,1,1,1.
- Backpressure:
  - Stimulus: out_ready[2]=0; send 8'h11 then 8'h22 to dest 2, then 8'h33 to dest 1.
  - Required: 8'h11 is held in channel 2 and in_ready=0 while 8'h22 waits.
  - Required: 8'h33 is not accepted until out_ready[2]=1. Then 8'h11, 8'h22 and 8'h33 deliver in order; cnt[2]=2, cnt[1]=1.
- Full throughput:
  - Stimulus: 16 back-to-back beats to dest 3, out_ready[3]=1.
  - Required: in_ready stays 1 throughout, out_valid[3] is high for 16 consecutive cycles, cnt[3]=16.
- Saturation and clear:
  - Stimulus: with CNT_W=4, deliver 20 beats to dest 0.
  - Required: cnt[0]=15. Asserting cnt_clr together with a delivery leaves cnt[0]=0.
- Async reset mid-flow:
  - Stimulus: out_ready=0000 with beats buffered in channels 0 and 1; pulse rst between clock edges.
  - Required: out_valid=0000 immediately with no clock edge, and counters are 0.

Source files
------------

// File: rtl/demux_stream_router.sv
// rtl/demux_stream_router.sv - registered 1:4 valid/ready stream demultiplexer with per-channel delivery counters
//
// Purpose:
//   Routes one ordered input stream to one of four output channels. The
//   channel is selected per beat by in_dest. Each channel holds one beat in
//   an output register. A stalled, full channel blocks the whole input stream
//   (head-of-line blocking). Each channel also has a saturating counter of
//   completed output handshakes, which can be cleared.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   input beat valid
//   in_ready   router can take the beat on in_data/in_dest (combinational)
//   in_data    input beat payload, WIDTH bits
//   in_dest    destination channel 0..3
//   out_valid  per-channel valid, bit i = channel i
//   out_ready  per-channel consumer ready
//   out_data   channel i payload at [i*WIDTH +: WIDTH]
//   cnt_clr    synchronous clear of all delivery counters
//   cnt        channel i delivery count at [i*CNT_W +: CNT_W]

module demux_stream_router #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_dest,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data,
    input  logic                 cnt_clr,
    output logic [4*CNT_W-1:0]   cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]       r_valid;
    logic [WIDTH-1:0] r_data [4];
    logic [CNT_W-1:0] r_cnt  [4];

    logic             w_accept;
    logic [3:0]       w_load;
    logic [3:0]       w_deliver;

    // The destination register can take a beat if it is empty, or if it is
    // being drained on this same edge. This gives 1 beat/cycle per channel.
    // in_valid is not used here, so in_ready does not depend on the producer.
    assign in_ready = ~r_valid[in_dest] | out_ready[in_dest];
    assign w_accept = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            assign w_load[gi]    = w_accept & (in_dest == 2'(gi));
            assign w_deliver[gi] = r_valid[gi] & out_ready[gi];

            // A load on the same edge as a delivery replaces the old beat
            // and keeps valid high. The data register is written only on a
            // load, so it stays stable while stalled and keeps its value
            // while idle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid[gi] <= 1'b0;
                    r_data[gi]  <= '0;
                end else if (w_load[gi]) begin
                    r_valid[gi] <= 1'b1;
                    r_data[gi]  <= in_data;
                end else if (w_deliver[gi]) begin
                    r_valid[gi] <= 1'b0;
                end
            end

            // Clear takes priority over a same-edge delivery. The counter
            // holds at all-ones instead of wrapping.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt[gi] <= '0;
                end else if (cnt_clr) begin
                    r_cnt[gi] <= '0;
                end else if (w_deliver[gi] && (r_cnt[gi] != CNT_MAX)) begin
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
                end
            end

            assign out_data[gi*WIDTH +: WIDTH] = r_data[gi];
            assign cnt[gi*CNT_W +: CNT_W]      = r_cnt[gi];
        end
    endgenerate

    assign out_valid = r_valid;

endmodule

// File: tb/tb_demux_stream_router.sv
// tb/tb_demux_stream_router.sv - self-checking bench for demux_stream_router

module tb_demux_stream_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_dest;
    logic [7:0]  in_data;
    logic [3:0]  out_ready;
    logic        cnt_clr;

    logic        in_ready_a, in_ready_b;
    logic [3:0]  out_valid_a, out_valid_b;
    logic [31:0] out_data_a, out_data_b;
    logic [31:0] cnt_a;
    logic [15:0] cnt_b;

    always #5 clk = ~clk;

    demux_stream_router #(.WIDTH(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_dest(in_dest), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .cnt_clr(cnt_clr), .cnt(cnt_a)
    );

    demux_stream_router #(.WIDTH(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_dest(in_dest), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .cnt_clr(cnt_clr), .cnt(cnt_b)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model: each channel is a one-slot mailbox plus an unbounded
    // delivery tally, clamped to the counter width only when compared.
    bit          m_full [4];
    logic [7:0]  m_slot [4];
    int          m_tally[4];
    logic        last_rdy;

    typedef struct {
        bit         iv;
        logic [1:0] dest;
        logic [7:0] data;
        logic [3:0] ordy;
        bit         clr;
        logic       exp_rdy;
        logic [3:0] exp_ov;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int clamp(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic logic model_ready();
        return (!m_full[in_dest]) || out_ready[in_dest];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_full[i] = 1'b0; m_slot[i] = 8'h00; m_tally[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit take;
        take = in_valid && model_ready();
        for (int i = 0; i < 4; i++) begin
            bit gone;
            gone = m_full[i] && out_ready[i];
            if (cnt_clr) m_tally[i] = 0;
            else if (gone) m_tally[i] = m_tally[i] + 1;
            if (gone) m_full[i] = 1'b0;
        end
        if (take) begin
            m_full[in_dest] = 1'b1;
            m_slot[in_dest] = in_data;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] ev;
        for (int i = 0; i < 4; i++) ev[i] = m_full[i];
        check({tag, " out_valid_a"}, {28'b0, out_valid_a}, {28'b0, ev});
        check({tag, " out_valid_b"}, {28'b0, out_valid_b}, {28'b0, ev});
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s data_a[%0d]", tag, i), {24'b0, out_data_a[i*8 +: 8]}, {24'b0, m_slot[i]});
            check($sformatf("%s data_b[%0d]", tag, i), {24'b0, out_data_b[i*8 +: 8]}, {24'b0, m_slot[i]});
            check($sformatf("%s cnt_a[%0d]", tag, i), {24'b0, cnt_a[i*8 +: 8]}, 32'(clamp(m_tally[i], 255)));
            check($sformatf("%s cnt_b[%0d]", tag, i), {28'b0, cnt_b[i*4 +: 4]}, 32'(clamp(m_tally[i], 15)));
        end
    endtask

    task automatic step(input bit iv, input logic [1:0] dest, input logic [7:0] data,
                        input logic [3:0] ordy, input bit clr, input string tag);
        in_valid = iv; in_dest = dest; in_data = data; out_ready = ordy; cnt_clr = clr;
        #1;
        last_rdy = in_ready_a;
        check({tag, " in_ready_a"}, {31'b0, in_ready_a}, {31'b0, model_ready()});
        check({tag, " in_ready_b"}, {31'b0, in_ready_b}, {31'b0, model_ready()});
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_dest = 2'd0; in_data = 8'h00;
        out_ready = 4'hF; cnt_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset out_valid", {28'b0, out_valid_a}, 32'h0);
        check("reset cnt_a", cnt_a, 32'h0);
        check("reset cnt_b", {16'b0, cnt_b}, 32'h0);
        check("reset out_data", out_data_a, 32'h0);
        check("reset in_ready", {31'b0, in_ready_a}, 32'h1);

        // Single routing: one pulse per channel, one edge after the accept.
        tbl[0] = '{1'b1, 2'd0, 8'hA0, 4'hF, 1'b0, 1'b1, 4'b0001};
        tbl[1] = '{1'b1, 2'd1, 8'hA1, 4'hF, 1'b0, 1'b1, 4'b0010};
        tbl[2] = '{1'b1, 2'd2, 8'hA2, 4'hF, 1'b0, 1'b1, 4'b0100};
        tbl[3] = '{1'b1, 2'd3, 8'hA3, 4'hF, 1'b0, 1'b1, 4'b1000};
        tbl[4] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b1, 4'b0000};
        for (int k = 0; k < 5; k++) begin
            step(tbl[k].iv, tbl[k].dest, tbl[k].data, tbl[k].ordy, tbl[k].clr, $sformatf("tbl%0d", k));
            check($sformatf("tbl%0d rdy", k), {31'b0, last_rdy}, {31'b0, tbl[k].exp_rdy});
            check($sformatf("tbl%0d ov", k), {28'b0, out_valid_a}, {28'b0, tbl[k].exp_ov});
            if (k < 4)
                check($sformatf("tbl%0d payload", k), {24'b0, out_data_a[k*8 +: 8]}, {24'b0, 8'hA0 + 8'(k)});
        end
        check("route cnt", cnt_a, 32'h01010101);

        // Backpressure and head-of-line blocking on channel 2.
        step(1'b0, 2'd0, 8'h00, 4'hF, 1'b1, "bp clr");
        step(1'b1, 2'd2, 8'h11, 4'b1011, 1'b0, "bp load11");
        check("bp held11", {24'b0, out_data_a[23:16]}, 32'h11);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'd2, 8'h22, 4'b1011, 1'b0, "bp stall");
            check("bp stall rdy", {31'b0, last_rdy}, 32'h0);
            check("bp stall data", {24'b0, out_data_a[23:16]}, 32'h11);
        end
        step(1'b1, 2'd2, 8'h22, 4'b1111, 1'b0, "bp release");
        check("bp release rdy", {31'b0, last_rdy}, 32'h1);
        check("bp data22", {24'b0, out_data_a[23:16]}, 32'h22);
        check("bp cnt2 first", {24'b0, cnt_a[23:16]}, 32'h1);
        step(1'b1, 2'd1, 8'h33, 4'b1111, 1'b0, "bp load33");
        check("bp data33", {24'b0, out_data_a[15:8]}, 32'h33);
        step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, "bp drain");
        check("bp cnt2", {24'b0, cnt_a[23:16]}, 32'h2);
        check("bp cnt1", {24'b0, cnt_a[15:8]}, 32'h1);

        // Full throughput on channel 3.
        step(1'b0, 2'd0, 8'h00, 4'hF, 1'b1, "tp clr");
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 2'd3, 8'(8'hC0 + k), 4'hF, 1'b0, "tp beat");
            check("tp rdy", {31'b0, last_rdy}, 32'h1);
            check("tp ov3", {31'b0, out_valid_a[3]}, 32'h1);
        end
        step(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, "tp drain");
        check("tp ov3 low", {31'b0, out_valid_a[3]}, 32'h0);
        check("tp cnt3", {24'b0, cnt_a[31:24]}, 32'd16);
        check("tp cnt3 sat4", {28'b0, cnt_b[15:12]}, 32'd15);

        // Saturation and clear on channel 0.
        step(1'b0, 2'd0, 8'h00, 4'hF, 1'b1, "sat clr");
        for (int k = 0; k < 20; k++) step(1'b1, 2'd0, 8'(k), 4'hF, 1'b0, "sat beat");
        step(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, "sat drain");
        check("sat cnt0 w4", {28'b0, cnt_b[3:0]}, 32'd15);
        check("sat cnt0 w8", {24'b0, cnt_a[7:0]}, 32'd20);
        step(1'b1, 2'd0, 8'h77, 4'hF, 1'b0, "sat load");
        step(1'b0, 2'd0, 8'h00, 4'hF, 1'b1, "sat clr+deliver");
        check("clr wins w4", {28'b0, cnt_b[3:0]}, 32'd0);
        check("clr wins w8", {24'b0, cnt_a[7:0]}, 32'd0);

        // Async reset between edges with beats buffered.
        step(1'b1, 2'd0, 8'h55, 4'h0, 1'b0, "ar load0");
        step(1'b1, 2'd1, 8'h66, 4'h0, 1'b0, "ar load1");
        check("ar buffered", {28'b0, out_valid_a}, 32'h3);
        #1 rst = 1'b1;
        #1;
        check("ar out_valid", {28'b0, out_valid_a}, 32'h0);
        check("ar cnt_a", cnt_a, 32'h0);
        check("ar cnt_b", {16'b0, cnt_b}, 32'h0);
        check("ar out_data", out_data_a, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
                 4'($urandom), $urandom_range(0, 40) == 0, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
